// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the FIFO read-side stream adapter
package fifo_pkg;

  localparam int STREAM_BUF_DEPTH = 2;

  typedef logic [1:0] cnt_t;

endpackage

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - FIFO read-strobe to valid/ready stream adapter
// Two-entry skid buffer; read credits cover the one-cycle FIFO read latency.
module fifo_rd_stream_adapter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  fifo_rd_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  input  logic                  fifo_rd_empty_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [1:0]            buffered_words_o
);

  cnt_t                  count_q, count_d;
  cnt_t                  wr_idx;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic                  pop;
  logic [2:0]            occ;

  assign pop = m_valid_o && m_ready_i;

  // Occupancy after this edge's pop, counting the word still in flight from the FIFO.
  assign occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_rd_o = !rst_i && !fifo_rd_empty_i && (occ < 3'(STREAM_BUF_DEPTH));

  always_comb begin
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    wr_idx  = count_q - cnt_t'(pop);
    count_d = count_q - cnt_t'(pop) + cnt_t'(inflight_q);
    if (pop && count_q == 2'd2) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (wr_idx == 2'd0) begin
        buf0_d = fifo_rd_data_i;
      end else begin
        buf1_d = fifo_rd_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= fifo_rd_o;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

  assign m_valid_o        = (count_q != 2'd0);
  assign m_data_o         = buf0_q;
  assign buffered_words_o = count_q;

endmodule
